// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep controller.
package tt_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } sweep_state_e;

    // Default number of function inputs
    localparam int unsigned DEF_N_IN = 4;

    // Golden table for F = (AB' + A'B)(C + D'), bit i = F({A,B,C,D} = i)
    localparam logic [15:0] DEF_EXPECTED = 16'h0DD0;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter used to hold each vector for the settle time.
module tt_settle_timer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] value_q;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_value;
        end else if (dec && (value_q != '0)) begin
            value_q <= value_q - WIDTH'(1);
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all input vectors to a combinational
// block, captures its output into a table and compares against a golden table.
// Optional first-mismatch capture is enabled by defining TT_SWEEP_FAIL_CAPTURE_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned        N_IN     = DEF_N_IN,
    parameter int unsigned        SETTLE   = 2,
    parameter logic [2**N_IN-1:0] EXPECTED = DEF_EXPECTED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   abcd,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2**N_IN-1:0] table_out,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_idx
);

    localparam int unsigned TBL_W = 2**N_IN;
    localparam int unsigned IDX_W = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TBL_W - 1);

    sweep_state_e state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic [TBL_W-1:0] table_q, table_sampled;
    logic             pass_q;
    logic             timer_load, timer_dec, timer_zero;
    logic [CNT_W-1:0] timer_value;
    logic             sweep_init, sample_en, last_vec;

    tt_settle_timer #(
        .WIDTH (CNT_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (CNT_W'(SETTLE - 1)),
        .dec        (timer_dec),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    assign last_vec = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control; start is only honoured when not busy
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        sweep_init = 1'b0;
        sample_en  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StDrive;
                    sweep_init = 1'b1;
                    timer_load = 1'b1;
                end
            end
            StDrive: begin
                if (timer_zero) begin
                    state_d = StSample;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StSample: begin
                sample_en = 1'b1;
                if (last_vec) begin
                    state_d = StDone;
                end else begin
                    state_d    = StDrive;
                    timer_load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Table with the current sample merged in, so pass can see the final bit
    always_comb begin
        table_sampled = table_q;
        table_sampled[idx_q[N_IN-1:0]] = f_in;
    end

    // Vector index, captured table and pass verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (sweep_init) begin
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else if (sample_en) begin
            table_q <= table_sampled;
            if (last_vec) begin
                pass_q <= (table_sampled == EXPECTED);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef TT_SWEEP_FAIL_CAPTURE_EN
    logic            fail_valid_q;
    logic [N_IN-1:0] fail_idx_q;

    // Latch only the first mismatching index of a sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
        end else if (sweep_init) begin
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
        end else if (sample_en && !fail_valid_q &&
                     (f_in != EXPECTED[idx_q[N_IN-1:0]])) begin
            fail_valid_q <= 1'b1;
            fail_idx_q   <= idx_q[N_IN-1:0];
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;
`else
    assign fail_valid = 1'b0;
    assign fail_idx   = '0;
`endif

    assign abcd      = idx_q[N_IN-1:0];
    assign busy      = (state_q == StDrive) || (state_q == StSample);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign table_out = table_q;

    // Unused in the default build; kept for observability
    logic unused_timer;
    assign unused_timer = ^timer_value;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl with the F dataflow block in the loop.
module tb_tt_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  abcd;
    logic        f_in;
    logic        busy, done, pass;
    logic [15:0] table_out;
    logic        fail_valid;
    logic [3:0]  fail_idx;

    int checks   = 0;
    int failures = 0;
    int fmode    = 0;  // 0 normal, 1 stuck-at-1, 2 invert at vector 5
    int lat;

    logic f_ideal;

    always #5 clk = ~clk;

    // F = (AB' + A'B)(C + D') with optional fault injection
    assign f_ideal = (abcd[3] ^ abcd[2]) & (abcd[1] | ~abcd[0]);
    assign f_in = (fmode == 1) ? 1'b1 :
                  ((fmode == 2) && (abcd == 4'd5)) ? ~f_ideal : f_ideal;

    tt_sweep_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abcd       (abcd),
        .f_in       (f_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .table_out  (table_out),
        .fail_valid (fail_valid),
        .fail_idx   (fail_idx)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start is sampled by exactly one posedge; returns at the negedge after it
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count edges since the start edge until done, optionally injecting starts
    task automatic wait_done(input bit inject, output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            if (inject && (cyc == 5 || cyc == 20)) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc == 2) check_val("abcd_c2", 32'(abcd), 32'd0);
            if (cyc == 3) check_val("abcd_c3", 32'(abcd), 32'd1);
            if (cyc == 47) check_val("abcd_c47", 32'(abcd), 32'd15);
        end
        start = 1'b0;
        if (cyc >= 200) check_val("done_timeout", 32'(cyc), 32'd48);
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_pass"}, 32'(pass), 32'd0);
        check_val({tag, "_table"}, 32'(table_out), 32'd0);
        check_val({tag, "_abcd"}, 32'(abcd), 32'd0);
        check_val({tag, "_fv"}, 32'(fail_valid), 32'd0);
        check_val({tag, "_fidx"}, 32'(fail_idx), 32'd0);
    endtask

    initial begin
        logic exp_fv;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: nominal sweep
        fmode = 0;
        pulse_start();
        check_val("t1_busy", 32'(busy), 32'd1);
        check_val("t1_abcd0", 32'(abcd), 32'd0);
        wait_done(1'b0, lat);
        check_val("t1_latency", 32'(lat), 32'd48);
        check_val("t1_table", 32'(table_out), 32'h0DD0);
        check_val("t1_pass", 32'(pass), 32'd1);
        check_val("t1_busy_done", 32'(busy), 32'd0);
        check_val("t1_abcd_hold", 32'(abcd), 32'd15);
        check_val("t1_fv", 32'(fail_valid), 32'd0);

        // 2: stuck-at-1
        fmode = 1;
        pulse_start();
        wait_done(1'b0, lat);
        check_val("t2_latency", 32'(lat), 32'd48);
        check_val("t2_table", 32'(table_out), 32'hFFFF);
        check_val("t2_pass", 32'(pass), 32'd0);
`ifdef TT_SWEEP_FAIL_CAPTURE_EN
        exp_fv = 1'b1;
`else
        exp_fv = 1'b0;
`endif
        check_val("t2_fv", 32'(fail_valid), 32'(exp_fv));
        check_val("t2_fidx", 32'(fail_idx), 32'd0);

        // 3: single-vector inversion at index 5
        fmode = 2;
        pulse_start();
        wait_done(1'b0, lat);
        check_val("t3_table", 32'(table_out), 32'h0DF0);
        check_val("t3_pass", 32'(pass), 32'd0);
        check_val("t3_fv", 32'(fail_valid), 32'(exp_fv));
        check_val("t3_fidx", 32'(fail_idx), exp_fv ? 32'd5 : 32'd0);

        // 4: start pulses while busy are ignored
        fmode = 0;
        pulse_start();
        wait_done(1'b1, lat);
        check_val("t4_latency", 32'(lat), 32'd48);
        check_val("t4_table", 32'(table_out), 32'h0DD0);
        check_val("t4_pass", 32'(pass), 32'd1);
        check_val("t4_fv", 32'(fail_valid), 32'd0);

        // 5: async reset mid-sweep
        pulse_start();
        repeat (19) @(negedge clk);
        check_val("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_zero("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("t5_idle_busy", 32'(busy), 32'd0);
        pulse_start();
        wait_done(1'b0, lat);
        check_val("t5_latency", 32'(lat), 32'd48);
        check_val("t5_pass", 32'(pass), 32'd1);

        // 6: restart from DONE
        pulse_start();
        check_val("t6_done", 32'(done), 32'd0);
        check_val("t6_table", 32'(table_out), 32'd0);
        check_val("t6_pass", 32'(pass), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd1);
        wait_done(1'b0, lat);
        check_val("t6_latency", 32'(lat), 32'd48);
        check_val("t6_table_end", 32'(table_out), 32'h0DD0);
        check_val("t6_pass_end", 32'(pass), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
